// File: rtl/usb_desc_pkg.sv
// Shared constants for USB standard device-descriptor handling:
// descriptor identity, field byte offsets, error codes and parser states.
package usb_desc_pkg;

    localparam logic [7:0] DESC_TYPE_DEVICE = 8'h01;
    localparam int         DEV_DESC_LEN     = 18;

    localparam int OFS_BLENGTH  = 0;
    localparam int OFS_TYPE     = 1;
    localparam int OFS_BCDUSB   = 2;
    localparam int OFS_CLASS    = 4;
    localparam int OFS_SUBCLASS = 5;
    localparam int OFS_PROTOCOL = 6;
    localparam int OFS_MPS0     = 7;
    localparam int OFS_VID      = 8;
    localparam int OFS_PID      = 10;
    localparam int OFS_BCDDEV   = 12;
    localparam int OFS_IMFR     = 14;
    localparam int OFS_IPROD    = 15;
    localparam int OFS_ISERIAL  = 16;
    localparam int OFS_NCFG     = 17;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_HDR   = 2'd1;
    localparam logic [1:0] ERR_SHORT = 2'd2;
    localparam logic [1:0] ERR_MPS   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARSE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } parse_state_t;

    // Endpoint-0 max packet size must be one of the four legal USB values.
    function automatic logic mps0_legal(input logic [7:0] mps);
        return (mps == 8'd8) || (mps == 8'd16) || (mps == 8'd32) || (mps == 8'd64);
    endfunction

endpackage

// File: rtl/usb_devdesc_parser.sv
// Receives the GET_DESCRIPTOR(Device) data stage, unpacks it into named
// little-endian fields and flags header, short-transfer and MPS0 errors.
module usb_devdesc_parser
    import usb_desc_pkg::*;
#(
    parameter int DESC_LEN = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  req_len,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [4:0]  byte_cnt,
    output logic [15:0] bcdUSB,
    output logic [15:0] idVendor,
    output logic [15:0] idProduct,
    output logic [15:0] bcdDevice,
    output logic [7:0]  bDeviceClass,
    output logic [7:0]  bDeviceSubClass,
    output logic [7:0]  bDeviceProtocol,
    output logic [7:0]  bMaxPacketSize0,
    output logic [7:0]  iManufacturer,
    output logic [7:0]  iProduct,
    output logic [7:0]  iSerialNumber,
    output logic [7:0]  bNumConfigurations
);

    localparam logic [4:0] LEN_MAX = 5'(DESC_LEN);

    parse_state_t state_reg;
    logic [4:0]   byte_cnt_reg;
    logic [4:0]   len_reg;
    logic [1:0]   err_reg;
    logic         done_reg;
    logic         busy_reg;

    // bLength and bDescriptorType are only checked, never stored.
    logic [7:0]   field_reg [OFS_BCDUSB:DESC_LEN-1];

    logic         accept;
    logic         hdr_bad;
    logic         mps_bad;
    logic [4:0]   cnt_inc;
    logic [4:0]   len_clamped;

    assign accept      = (state_reg == ST_PARSE) && rx_valid && !start;
    assign cnt_inc     = byte_cnt_reg + 5'd1;
    assign len_clamped = ((req_len == 5'd0) || (req_len > LEN_MAX)) ? LEN_MAX : req_len;
    assign hdr_bad     = ((byte_cnt_reg == 5'(OFS_BLENGTH)) && (rx_data != 8'(DEV_DESC_LEN)))
                       || ((byte_cnt_reg == 5'(OFS_TYPE)) && (rx_data != DESC_TYPE_DEVICE));
    assign mps_bad     = (byte_cnt_reg == 5'(OFS_MPS0)) && !mps0_legal(rx_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= 5'd0;
            len_reg      <= 5'd0;
            err_reg      <= ERR_NONE;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                // A start from any state restarts cleanly, aborting silently.
                state_reg    <= ST_PARSE;
                busy_reg     <= 1'b1;
                byte_cnt_reg <= 5'd0;
                err_reg      <= ERR_NONE;
                len_reg      <= len_clamped;
            end else if (accept) begin
                byte_cnt_reg <= cnt_inc;
                if (hdr_bad || mps_bad) begin
                    state_reg <= ST_ERR;
                    busy_reg  <= 1'b0;
                    err_reg   <= hdr_bad ? ERR_HDR : ERR_MPS;
                end else if (cnt_inc == len_reg) begin
                    state_reg <= ST_DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end else if (rx_last) begin
                    state_reg <= ST_ERR;
                    busy_reg  <= 1'b0;
                    err_reg   <= ERR_SHORT;
                end
            end
        end
    end

    generate
        for (genvar gi = OFS_BCDUSB; gi < DESC_LEN; gi++) begin : g_field
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    field_reg[gi] <= 8'd0;
                end else if (start) begin
                    field_reg[gi] <= 8'd0;
                end else if (accept && (byte_cnt_reg == 5'(gi))) begin
                    field_reg[gi] <= rx_data;
                end
            end
        end
    endgenerate

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign byte_cnt = byte_cnt_reg;

    assign bcdUSB             = {field_reg[OFS_BCDUSB + 1], field_reg[OFS_BCDUSB]};
    assign idVendor           = {field_reg[OFS_VID + 1],    field_reg[OFS_VID]};
    assign idProduct          = {field_reg[OFS_PID + 1],    field_reg[OFS_PID]};
    assign bcdDevice          = {field_reg[OFS_BCDDEV + 1], field_reg[OFS_BCDDEV]};
    assign bDeviceClass       = field_reg[OFS_CLASS];
    assign bDeviceSubClass    = field_reg[OFS_SUBCLASS];
    assign bDeviceProtocol    = field_reg[OFS_PROTOCOL];
    assign bMaxPacketSize0    = field_reg[OFS_MPS0];
    assign iManufacturer      = field_reg[OFS_IMFR];
    assign iProduct           = field_reg[OFS_IPROD];
    assign iSerialNumber      = field_reg[OFS_ISERIAL];
    assign bNumConfigurations = field_reg[OFS_NCFG];

endmodule
